// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multicycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB) on one
// word-addressed req/ack memory port, with a retire port for every register write.
module cpu_multicycle #(
    parameter int          XLEN     = 32,
    parameter int          NREGS    = 32,
    parameter int          AW       = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            wb_valid,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data,
    output logic            halted,
    output logic            illegal
);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_J = 6'h02, OP_HALT = 6'h3F;

    logic [2:0]      state;
    logic [AW-1:0]   pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] a, b;
    logic [XLEN-1:0] rf [NREGS];

    logic [5:0]      op, funct;
    logic [RW-1:0]   rs_i, rt_i, dst;
    logic [SW-1:0]   sh;
    logic [XLEN-1:0] simm, sum_i, alu;
    logic [AW-1:0]   pc_inc, jb_pc;
    logic            r_ok, legal;

    always_comb begin
        op     = ir[31:26];
        funct  = ir[5:0];
        rs_i   = ir[21+:RW];
        rt_i   = ir[16+:RW];
        dst    = op == OP_R ? ir[11+:RW] : rt_i;
        sh     = SW'(ir[10:6]);
        simm   = XLEN'($signed(ir[15:0]));
        sum_i  = a + simm;
        r_ok   = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        legal  = (op == OP_R && r_ok) || op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT};
        alu    = funct == 6'h20 ? a + b :
                 funct == 6'h22 ? a - b :
                 funct == 6'h24 ? a & b :
                 funct == 6'h25 ? a | b :
                 funct == 6'h2A ? XLEN'($signed(a) < $signed(b)) :
                 funct == 6'h00 ? b << sh : b >> sh;
        pc_inc = pc + AW'(1);
        jb_pc  = op == OP_J ? AW'(ir[25:0]) : (a == b ? pc_inc + simm[AW-1:0] : pc_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= AW'(RESET_PC);
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    // only the first fetch after reset arrives here with req low
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        ir      <= 32'(mem_rdata);
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= rf[rs_i];
                    b     <= rf[rt_i];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!legal || op == OP_HALT) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        illegal <= !legal;
                    end else if (op == OP_LW || op == OP_SW) begin
                        pc        <= pc_inc;
                        mem_req   <= 1'b1;
                        mem_we    <= op == OP_SW;
                        mem_addr  <= sum_i[AW-1:0];
                        mem_wdata <= b;
                        state     <= S_MEM;
                    end else if (op == OP_BEQ || op == OP_J) begin
                        pc       <= jb_pc;
                        mem_req  <= 1'b1;
                        mem_addr <= jb_pc;
                        state    <= S_FETCH;
                    end else begin
                        pc       <= pc_inc;
                        wb_valid <= 1'b1;
                        wb_reg   <= 5'(dst);
                        wb_data  <= op == OP_R ? alu : sum_i;
                        state    <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        if (op == OP_LW) begin
                            mem_req  <= 1'b0;
                            wb_valid <= 1'b1;
                            wb_reg   <= 5'(dst);
                            wb_data  <= mem_rdata;
                            state    <= S_WB;
                        end else begin
                            mem_addr <= pc;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (dst != '0) rf[dst] <= wb_data;
                    mem_req  <= 1'b1;
                    mem_addr <= pc;
                    state    <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed programs against a variable-wait memory model;
// expected retire pairs are queued up front and a monitor pops them on wb_valid.
module tb_cpu_multicycle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        wb_valid, halted, illegal;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    localparam logic [31:0] HLT = 32'hFC00_0000;

    logic [31:0] mem [4096];
    int          fcnt [4096];
    int          ack_cyc [4096];
    int          waits = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    logic [4:0]  exp_r [$];
    logic [31:0] exp_d [$];
    logic [4:0]  er;
    logic [31:0] ed;

    cpu_multicycle #(.XLEN(32), .NREGS(32), .AW(12), .RESET_PC(16)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_ack   = mem_req && (wcnt == waits);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (mem_req && mem_ack) begin
            wcnt <= 0;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else begin
                fcnt[mem_addr]    = fcnt[mem_addr] + 1;
                ack_cyc[mem_addr] = cyc;
            end
        end else if (mem_req) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp_v);
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_r.size() == 0) chk("wb_unexpected_reg", 32'(wb_reg), 32'hFFFF_FFFF);
            else begin
                er = exp_r.pop_front();
                ed = exp_d.pop_front();
                chk("wb_reg", 32'(wb_reg), 32'(er));
                chk("wb_data", wb_data, ed);
            end
        end
    end

    function automatic logic [31:0] ri(input logic [5:0] f, input logic [4:0] rd, rs, rt, sh);
        return {6'd0, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] op, input logic [4:0] rt, rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        exp_r.push_back(r);
        exp_d.push_back(d);
    endtask

    task automatic do_reset(input int w);
        @(negedge clk);
        rst = 1'b1;
        #1;
        waits = w;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = '0;
            fcnt[i] = 0;
            ack_cyc[i] = 0;
        end
        exp_r.delete();
        exp_d.delete();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string nm, input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, 32'(halted), 32'd1);
    endtask

    task automatic drained(input string nm);
        repeat (2) @(negedge clk);
        chk(nm, 32'(exp_r.size()), 32'd0);
    endtask

    initial begin
        int n, bad;
        // reset state
        do_reset(0);
        repeat (2) @(negedge clk);
        chk("reset_outputs", {18'd0, mem_req, mem_we, mem_addr}, 32'd0);
        chk("reset_flags", {24'd0, wb_valid, halted, illegal, wb_reg}, 32'd0);
        chk("reset_wdata", mem_wdata | wb_data, 32'd0);

        // basic add sequence, zero wait
        mem[16] = ii(6'h08, 5'd1, 5'd0, 16'd5);
        mem[17] = ii(6'h08, 5'd2, 5'd0, 16'd7);
        mem[18] = ri(6'h20, 5'd3, 5'd1, 5'd2, 5'd0);
        mem[19] = HLT;
        push(5'd1, 32'd5); push(5'd2, 32'd7); push(5'd3, 32'd12);
        release_rst();
        wait_halt("t1_halted", 100, n);
        chk("t1_halt_cycles", 32'(n), 32'd16);
        chk("t1_illegal", 32'(illegal), 32'd0);
        chk("t1_addi_lat", 32'(ack_cyc[17] - ack_cyc[16]), 32'd4);
        chk("t1_add_lat", 32'(ack_cyc[19] - ack_cyc[18]), 32'd4);
        chk("t1_req_idle", 32'(mem_req), 32'd0);
        drained("t1_drained");

        // store then load, three wait states
        do_reset(3);
        mem[16] = ii(6'h08, 5'd3, 5'd0, 16'd12);
        mem[17] = ii(6'h2B, 5'd3, 5'd0, 16'd20);
        mem[18] = ii(6'h23, 5'd4, 5'd0, 16'd20);
        mem[19] = HLT;
        push(5'd3, 32'd12); push(5'd4, 32'd12);
        release_rst();
        wait_halt("t2_halted", 300, n);
        chk("t2_mem20", mem[20], 32'd12);
        chk("t2_sw_lat", 32'(ack_cyc[18] - ack_cyc[17]), 32'd10);
        chk("t2_lw_lat", 32'(ack_cyc[19] - ack_cyc[18]), 32'd11);
        drained("t2_drained");

        // beq not taken, jump to top of memory, wrap to 0
        do_reset(0);
        mem[16] = ii(6'h08, 5'd1, 5'd0, 16'd3);
        mem[17] = ii(6'h08, 5'd2, 5'd0, 16'd4);
        mem[18] = ii(6'h04, 5'd2, 5'd1, 16'hFFFF);
        mem[19] = {6'h02, 26'hFFF};
        mem[4095] = ii(6'h08, 5'd6, 5'd0, 16'd1);
        mem[0] = HLT;
        push(5'd1, 32'd3); push(5'd2, 32'd4); push(5'd6, 32'd1);
        release_rst();
        wait_halt("t3_halted", 200, n);
        chk("t3_beq_nt_lat", 32'(ack_cyc[19] - ack_cyc[18]), 32'd3);
        chk("t3_j_lat", 32'(ack_cyc[4095] - ack_cyc[19]), 32'd3);
        chk("t3_wrap_lat", 32'(ack_cyc[0] - ack_cyc[4095]), 32'd4);
        chk("t3_fetch_fff", 32'(fcnt[4095]), 32'd1);
        drained("t3_drained");

        // beq taken onto itself
        do_reset(0);
        mem[16] = ii(6'h08, 5'd1, 5'd0, 16'd3);
        mem[17] = ii(6'h08, 5'd2, 5'd0, 16'd3);
        mem[18] = ii(6'h04, 5'd2, 5'd1, 16'hFFFF);
        mem[19] = HLT;
        push(5'd1, 32'd3); push(5'd2, 32'd3);
        release_rst();
        repeat (40) @(negedge clk);
        chk("t4_loop_running", 32'(halted), 32'd0);
        chk("t4_no_fallthru", 32'(fcnt[19]), 32'd0);
        chk("t4_loop_fetches", 32'(fcnt[18] >= 5), 32'd1);
        drained("t4_drained");

        // r0 discard and ALU corners
        do_reset(0);
        mem[16] = ii(6'h08, 5'd1, 5'd0, 16'd1);
        mem[17] = ii(6'h08, 5'd0, 5'd0, 16'd9);
        mem[18] = ri(6'h20, 5'd5, 5'd0, 5'd0, 5'd0);
        mem[19] = ri(6'h22, 5'd6, 5'd0, 5'd1, 5'd0);
        mem[20] = ii(6'h08, 5'd2, 5'd0, 16'hFFFF);
        mem[21] = ri(6'h2A, 5'd7, 5'd2, 5'd1, 5'd0);
        mem[22] = ri(6'h2A, 5'd12, 5'd1, 5'd2, 5'd0);
        mem[23] = ri(6'h00, 5'd8, 5'd0, 5'd1, 5'd31);
        mem[24] = ri(6'h02, 5'd9, 5'd0, 5'd2, 5'd28);
        mem[25] = ri(6'h24, 5'd10, 5'd2, 5'd1, 5'd0);
        mem[26] = ri(6'h25, 5'd11, 5'd1, 5'd8, 5'd0);
        mem[27] = HLT;
        push(5'd1, 32'd1); push(5'd0, 32'd9); push(5'd5, 32'd0);
        push(5'd6, 32'hFFFF_FFFF); push(5'd2, 32'hFFFF_FFFF); push(5'd7, 32'd1);
        push(5'd12, 32'd0); push(5'd8, 32'h8000_0000); push(5'd9, 32'h0000_000F);
        push(5'd10, 32'd1); push(5'd11, 32'h8000_0001);
        release_rst();
        wait_halt("t5_halted", 300, n);
        chk("t5_illegal", 32'(illegal), 32'd0);
        drained("t5_drained");

        // undefined opcode
        do_reset(0);
        mem[16] = ii(6'h08, 5'd1, 5'd0, 16'd1);
        mem[17] = {6'h3E, 26'd0};
        push(5'd1, 32'd1);
        release_rst();
        wait_halt("t6_halted", 100, n);
        chk("t6_illegal", 32'(illegal), 32'd1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) bad++;
        end
        chk("t6_req_quiet", 32'(bad), 32'd0);
        drained("t6_drained");

        // undefined funct
        do_reset(0);
        mem[16] = ri(6'h21, 5'd3, 5'd0, 5'd0, 5'd0);
        release_rst();
        wait_halt("t7_halted", 100, n);
        chk("t7_illegal", 32'(illegal), 32'd1);
        drained("t7_drained");

        // reset while a store is waiting for ack
        do_reset(20);
        mem[16] = ii(6'h08, 5'd1, 5'd0, 16'd7);
        mem[17] = ii(6'h2B, 5'd1, 5'd0, 16'd20);
        push(5'd1, 32'd7);
        release_rst();
        n = 0;
        while (!(mem_req && mem_we) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t8_store_seen", 32'(mem_req && mem_we), 32'd1);
        chk("t8_pre_drained", 32'(exp_r.size()), 32'd0);
        rst = 1'b1;
        #1;
        chk("t8_req_async_drop", 32'(mem_req), 32'd0);
        do_reset(0);
        mem[16] = ri(6'h20, 5'd2, 5'd1, 5'd0, 5'd0);
        mem[17] = HLT;
        push(5'd2, 32'd0);
        release_rst();
        @(posedge clk);
        #1;
        chk("t8_restart_fetch", {19'd0, mem_req, mem_addr}, {19'd0, 1'b1, 12'd16});
        wait_halt("t8_halted", 100, n);
        chk("t8_illegal", 32'(illegal), 32'd0);
        drained("t8_drained");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
